row_requantise_serialiser: RTL



---
 rtl/row_requantise_serialiser.sv | 128 ++++++++++++
 1 files changed

// File: rtl/row_requantise_serialiser.sv
// Requantises a packed row of 2W-bit accumulators to W-bit activations, one element
// per cycle through a shared round/ReLU/saturate datapath, and presents the row with valid/ready.
module row_requantise_serialiser #(
    parameter int W     = 16,
    parameter int D     = 8,
    parameter int SHIFT = 12,
    parameter int RELU  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*D*W-1:0]   packed_in,
    input  logic               in_v,
    output logic               in_ready,
    output logic [D*W-1:0]     packed_out,
    output logic               out_v,
    input  logic               out_ready,
    output logic               out_sat
);

    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    // Half-LSB rounding constant; collapses to zero when SHIFT is zero.
    localparam logic [2*W:0] RND = ({{(2*W){1'b0}}, 1'b1} << SHIFT) >> 1;
    localparam logic signed [2*W:0] MAXV = $signed({{(W+2){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [2*W:0] MINV = $signed({{(W+2){1'b1}}, {(W-1){1'b0}}});

    // Returns {saturated, result}; one guard bit keeps the rounding add from overflowing.
    function automatic logic [W:0] requant(input logic [2*W-1:0] x);
        logic signed [2*W:0] v;
        logic signed [2*W:0] r;
        logic [W:0]          res;
        v = $signed({x[2*W-1], x}) + $signed(RND);
        if ((RELU != 0) && v[2*W]) begin
            r = '0;
        end else begin
            r = v >>> SHIFT;
        end
        if (r > MAXV) begin
            res = {1'b1, MAXV[W-1:0]};
        end else if (r < MINV) begin
            res = {1'b1, MINV[W-1:0]};
        end else begin
            res = {1'b0, r[W-1:0]};
        end
        return res;
    endfunction

    logic [1:0]          r_state;
    logic [2*D*W-1:0]    r_buf;
    logic [IW-1:0]       r_idx;
    logic                r_sat;
    logic [D*W-1:0]      r_out;
    logic                r_in_ready;
    logic                r_out_v;
    logic                r_out_sat;

    logic [IW-1:0]       w_slot;
    logic [2*W-1:0]      w_elem;
    logic [W:0]          w_q;

    // Element 0 sits in the MSB slice, so the slot counts down as idx counts up.
    always_comb begin
        w_slot = LAST_IDX - r_idx;
        w_elem = r_buf[w_slot*2*W +: 2*W];
        w_q    = requant(w_elem);
    end

    // Row FSM: capture, serial requantise, hold until the consumer takes the row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_buf      <= '0;
            r_idx      <= '0;
            r_sat      <= 1'b0;
            r_out      <= '0;
            r_in_ready <= 1'b1;
            r_out_v    <= 1'b0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_v) begin
                        r_buf      <= packed_in;
                        r_sat      <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PROC;
                    end
                end
                S_PROC: begin
                    r_out[w_slot*W +: W] <= w_q[W-1:0];
                    r_sat                <= r_sat | w_q[W];
                    if (r_idx == LAST_IDX) begin
                        r_out_v   <= 1'b1;
                        r_out_sat <= r_sat | w_q[W];
                        r_state   <= S_HOLD;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_v    <= 1'b0;
                        r_out_sat  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_out_v    <= 1'b0;
                    r_out_sat  <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign packed_out = r_out;
    assign out_v      = r_out_v;
    assign out_sat    = r_out_sat;

endmodule
